// File: rtl/conv_job_scheduler.sv
// Convolution job scheduler: queues base-address descriptors and sequences the MAC controller one job at a time.
// Optional watchdog abort on a stuck RUN is enabled by defining WATCHDOG_EN.
module conv_job_scheduler #(
    parameter int DEPTH     = 4,
    parameter int IMG_AW    = 10,
    parameter int WGT_AW    = 8,
    parameter int OUT_AW    = 13,
    parameter int START_GAP = 2,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [IMG_AW-1:0] job_img_base,
    input  logic [WGT_AW-1:0] job_wgt_base,
    input  logic [OUT_AW-1:0] job_out_base,
    output logic              mac_start,
    output logic [IMG_AW-1:0] mac_img_base,
    output logic [WGT_AW-1:0] mac_wgt_base,
    output logic [OUT_AW-1:0] mac_out_base,
    input  logic              mac_done,
    output logic              busy,
    output logic [CNT_W-1:0]  jobs_done,
    output logic              drained,
    output logic              err
);
    localparam int PW       = $clog2(DEPTH);
    localparam int DW       = IMG_AW + WGT_AW + OUT_AW;
    localparam int GW       = (START_GAP > 1) ? $clog2(START_GAP) : 1;
    localparam int GAP_LAST = (START_GAP > 1) ? START_GAP - 1 : 0;

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, GAP} state_t;

    state_t            state_reg, state_next;
    logic [DW-1:0]     mem [DEPTH];
    logic [PW:0]       wr_ptr_reg, rd_ptr_reg;
    logic [GW-1:0]     gap_cnt_reg;
    logic [CNT_W-1:0]  jobs_done_reg;
    logic              drained_reg, drained_next;
    logic              full, empty, push, pop, gap_last, run_exit;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                      (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign push     = job_valid && !full;
    assign pop      = (state_reg == LOAD);
    assign gap_last = (START_GAP <= 1) || (gap_cnt_reg == GW'(GAP_LAST));

`ifdef WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_cnt_reg;
    logic           timeout;

    assign timeout  = (wd_cnt_reg == WDW'(TIMEOUT - 1));
    assign err      = (state_reg == RUN) && !mac_done && timeout;
    assign run_exit = mac_done || timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt_reg <= '0;
        else if (state_reg == RUN)
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
        else
            wd_cnt_reg <= '0;
    end
`else
    assign err      = 1'b0;
    assign run_exit = mac_done;
`endif

    always_comb begin
        state_next   = state_reg;
        drained_next = 1'b0;
        case (state_reg)
            IDLE:  if (!empty) state_next = LOAD;
            LOAD:  state_next = START;
            START: state_next = RUN;
            RUN:   if (run_exit) state_next = GAP;
            GAP: begin
                if (gap_last) begin
                    if (!empty) begin
                        state_next = LOAD;
                    end else begin
                        state_next   = IDLE;
                        drained_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Descriptor storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg[PW-1:0]] <= {job_img_base, job_wgt_base, job_out_base};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            gap_cnt_reg   <= '0;
            jobs_done_reg <= '0;
            drained_reg   <= 1'b0;
            mac_img_base  <= '0;
            mac_wgt_base  <= '0;
            mac_out_base  <= '0;
        end else begin
            state_reg   <= state_next;
            drained_reg <= drained_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                {mac_img_base, mac_wgt_base, mac_out_base} <= mem[rd_ptr_reg[PW-1:0]];
            end
            if (state_reg == GAP)
                gap_cnt_reg <= gap_cnt_reg + 1'b1;
            else
                gap_cnt_reg <= '0;
            if (state_reg == RUN && state_next == GAP)
                jobs_done_reg <= jobs_done_reg + 1'b1;
        end
    end

    assign job_ready = !full;
    assign mac_start = (state_reg == START);
    assign busy      = (state_reg != IDLE);
    assign jobs_done = jobs_done_reg;
    assign drained   = drained_reg;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Directed self-checking bench for conv_job_scheduler (default build, START_GAP=2, DEPTH=4).
module tb_conv_job_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [9:0]  job_img_base = '0;
    logic [7:0]  job_wgt_base = '0;
    logic [12:0] job_out_base = '0;
    logic        mac_start;
    logic [9:0]  mac_img_base;
    logic [7:0]  mac_wgt_base;
    logic [12:0] mac_out_base;
    logic        mac_done = 1'b0;
    logic        busy;
    logic [15:0] jobs_done;
    logic        drained;
    logic        err;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int drained_cnt = 0;
    int exp_jobs = 0;

    conv_job_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_img_base(job_img_base), .job_wgt_base(job_wgt_base), .job_out_base(job_out_base),
        .mac_start(mac_start), .mac_img_base(mac_img_base), .mac_wgt_base(mac_wgt_base),
        .mac_out_base(mac_out_base), .mac_done(mac_done), .busy(busy),
        .jobs_done(jobs_done), .drained(drained), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mac_start) start_cnt <= start_cnt + 1;
        if (drained) drained_cnt <= drained_cnt + 1;
    end

    typedef struct {
        logic [9:0]  img;
        logic [7:0]  wgt;
        logic [12:0] out;
        int          run;
        int          exp_n;
        logic        exp_drain;
    } job_t;
    job_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [9:0] img, input logic [7:0] wgt, input logic [12:0] out);
        job_valid = 1'b1;
        job_img_base = img;
        job_wgt_base = wgt;
        job_out_base = out;
        step();
        job_valid = 1'b0;
        $display("push img=%h wgt=%h out=%h", img, wgt, out);
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!mac_start && n < 100) begin
            step();
            n++;
        end
        $display("start after %0d cycles img=%h wgt=%h out=%h", n, mac_img_base, mac_wgt_base, mac_out_base);
    endtask

    task automatic complete(output int n, output logic got_start, output logic got_drained);
        mac_done = 1'b1;
        n = 0;
        got_start = 1'b0;
        got_drained = 1'b0;
        while (!got_start && !got_drained && n < 50) begin
            step();
            mac_done = 1'b0;
            n++;
            got_start = mac_start;
            got_drained = drained;
        end
        $display("done -> %0d cycles start=%0b drained=%0b jobs_done=%0d", n, got_start, got_drained, jobs_done);
    endtask

    task automatic check_bases(input string name, input logic [9:0] img, input logic [7:0] wgt,
                               input logic [12:0] out);
        check({name, "_img"}, 32'(mac_img_base), 32'(img));
        check({name, "_wgt"}, 32'(mac_wgt_base), 32'(wgt));
        check({name, "_out"}, 32'(mac_out_base), 32'(out));
    endtask

    initial begin
        int n, d0, s0;
        logic gs, gd;

        tbl[0] = '{10'h101, 8'h11, 13'h0A00, 5, 4, 1'b0};
        tbl[1] = '{10'h202, 8'h22, 13'h0B00, 7, 4, 1'b0};
        tbl[2] = '{10'h303, 8'h33, 13'h0C00, 3, 4, 1'b0};
        tbl[3] = '{10'h3F4, 8'h44, 13'h1D00, 9, 3, 1'b1};

        repeat (3) step();
        check("rst_ready", 32'(job_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_start", 32'(mac_start), 0);
        check("rst_jobs", 32'(jobs_done), 0);
        check("rst_drained", 32'(drained), 0);
        check("rst_err", 32'(err), 0);
        check_bases("rst", 10'h0, 8'h0, 13'h0);
        rst_n = 1'b1;
        step();

        // Single job
        push(10'h010, 8'h20, 13'h0100);
        wait_start(n);
        check("single_latency", 32'(n), 2);
        check_bases("single", 10'h010, 8'h20, 13'h0100);
        step();
        check("single_start_1cyc", 32'(mac_start), 0);
        repeat (49) step();
        complete(n, gs, gd);
        exp_jobs++;
        check("single_drain_cycles", 32'(n), 3);
        check("single_drained", 32'(gd), 1);
        check("single_jobs", 32'(jobs_done), 32'(exp_jobs));
        check("single_busy", 32'(busy), 0);
        step();
        check("single_drained_1cyc", 32'(drained), 0);

        // Back-to-back: lead job occupies RUN while the FIFO is filled
        push(10'h0AA, 8'h0B, 13'h0CC);
        wait_start(n);
        step();
        for (int i = 0; i < 4; i++) begin
            check("fill_ready", 32'(job_ready), 1);
            push(tbl[i].img, tbl[i].wgt, tbl[i].out);
        end
        check("full_ready", 32'(job_ready), 0);
        push(10'h3FF, 8'hFF, 13'h1FFF);
        d0 = drained_cnt;
        complete(n, gs, gd);
        exp_jobs++;
        check("lead_gap", 32'(n), 4);
        for (int i = 0; i < 4; i++) begin
            check("b2b_start", 32'(mac_start), 1);
            check_bases("b2b", tbl[i].img, tbl[i].wgt, tbl[i].out);
            repeat (tbl[i].run) step();
            complete(n, gs, gd);
            exp_jobs++;
            check("b2b_gap", 32'(n), 32'(tbl[i].exp_n));
            check("b2b_drain", 32'(gd), 32'(tbl[i].exp_drain));
        end
        s0 = start_cnt;
        repeat (10) step();
        check("b2b_fifth_dropped", 32'(start_cnt - s0), 0);
        check("b2b_one_drain", 32'(drained_cnt - d0), 1);
        check("b2b_jobs", 32'(jobs_done), 32'(exp_jobs));

        // Spurious done in IDLE and in START
        mac_done = 1'b1;
        repeat (3) step();
        mac_done = 1'b0;
        check("idle_done_jobs", 32'(jobs_done), 32'(exp_jobs));
        check("idle_done_busy", 32'(busy), 0);
        push(10'h055, 8'h66, 13'h0777);
        wait_start(n);
        d0 = drained_cnt;
        mac_done = 1'b1;
        step();
        mac_done = 1'b0;
        repeat (10) step();
        check("start_done_busy", 32'(busy), 1);
        check("start_done_jobs", 32'(jobs_done), 32'(exp_jobs));
        check("start_done_nodrain", 32'(drained_cnt - d0), 0);
        complete(n, gs, gd);
        exp_jobs++;
        check("spur_drain_cycles", 32'(n), 3);
        check("spur_jobs", 32'(jobs_done), 32'(exp_jobs));

        // Push during GAP
        push(10'h111, 8'h12, 13'h0113);
        wait_start(n);
        repeat (5) step();
        d0 = drained_cnt;
        mac_done = 1'b1;
        step();
        mac_done = 1'b0;
        exp_jobs++;
        push(10'h222, 8'h23, 13'h0224);
        step();
        check("gap_push_drained", 32'(drained), 0);
        check("gap_push_busy", 32'(busy), 1);
        step();
        check("gap_push_start", 32'(mac_start), 1);
        check_bases("gap_push", 10'h222, 8'h23, 13'h0224);
        check("gap_push_nodrain", 32'(drained_cnt - d0), 0);
        repeat (4) step();
        complete(n, gs, gd);
        exp_jobs++;
        check("gap_push_final_drain", 32'(gd), 1);
        check("gap_push_jobs", 32'(jobs_done), 32'(exp_jobs));

        // Reset mid-RUN with two jobs queued
        push(10'h333, 8'h34, 13'h0335);
        wait_start(n);
        step();
        push(10'h001, 8'h02, 13'h0003);
        push(10'h004, 8'h05, 13'h0006);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_jobs", 32'(jobs_done), 0);
        check("mid_rst_ready", 32'(job_ready), 1);
        check_bases("mid_rst", 10'h0, 8'h0, 13'h0);
        repeat (2) step();
        rst_n = 1'b1;
        s0 = start_cnt;
        repeat (10) step();
        check("post_rst_nostart", 32'(start_cnt - s0), 0);
        check("post_rst_busy", 32'(busy), 0);
        push(10'h3AB, 8'hCD, 13'h1EF0);
        wait_start(n);
        check("post_rst_latency", 32'(n), 2);
        check_bases("post_rst", 10'h3AB, 8'hCD, 13'h1EF0);
        repeat (3) step();
        complete(n, gs, gd);
        check("post_rst_jobs", 32'(jobs_done), 1);
        check("post_rst_err", 32'(err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
